id_decode_unit: RTL and testbench
=================================

ID_DECODE_UNIT -- requirements
Module: id_decode_unit

Interface
REQ-001 CLK  input  1  rising-edge clock for the register-file write port.
REQ-002 RESET  input  1  asynchronous, active-low reset; clock CLK.
REQ-003 Instr  input  32  MIPS-I instruction under decode.
REQ-004 PC_Plus4  input  32  address of Instr plus 4.
REQ-005 WriteReg / WriteData / Write  input  5/32/1  writeback port: register index, data, enable.
REQ-006 DataA / DataB / DataC  output  32  combinational reads of rs (Instr[25:21]), rt (Instr[20:16]) and the destination register.
REQ-007 DestReg  output  5  RegDest ? rd : (Link ? 31 : rt).
REQ-008 Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall  output  1 each  decoded control flags.
REQ-009 ALUControl  output  6  operation code.
REQ-010 NextAddr  output  32  branch/jump target.

Function
REQ-011 Decode SHALL be purely combinational; all outputs except register contents respond in the same cycle as Instr.
REQ-012 Supported instructions:
- SPECIAL: ADD(U), SUB(U), AND, OR, XOR, NOR, SLT(U), SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR, SYSCALL.
- REGIMM: BLTZ, BGEZ, BLTZAL, BGEZAL.
- Jumps/branches: J, JAL, BEQ, BNE, BLEZ, BGTZ.
- Immediate ALU: ADDI(U), SLTI(U), ANDI, ORI, XORI, LUI.
- Memory: LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-013 ALUControl SHALL be the funct field for opcode 0, otherwise the opcode (REGIMM: {1'b1, rt}).
REQ-014 RegDest=1 for SPECIAL ops except JR/SYSCALL; Link=1 for JAL, JALR, BLTZAL, BGEZAL; Jump=1 for J, JAL, JR, JALR; JumpRegister=1 for JR, JALR; Branch=1 for all conditional branches.
REQ-015 ALUSrc=1 for immediate ALU ops, loads and stores; SignOrZero=1 except ANDI, ORI, XORI (zero-extend).
REQ-016 RegWrite=1 for ALU ops, loads and link instructions; 0 for stores, non-link branches/jumps, SYSCALL, unsupported encodings.
REQ-017 Unsupported encodings SHALL decode as a NOP: all flags 0, ALUControl 0.
REQ-018 NextAddr:
- J/JAL: {PC_Plus4[31:28], Instr[25:0], 2'b00}.
- JR/JALR: DataA.
- Otherwise: PC_Plus4 + (sign-extended Instr[15:0] << 2), 32-bit wrap-around.
REQ-019 Register file: 32x32; register 0 reads 0 always; write on rising CLK when Write=1 and WriteReg!=0.
REQ-020 Simultaneous writes to and reads of the same register: behaviour per REQ-024.

Reset
REQ-021 RESET low SHALL clear all 32 registers to 0 immediately; writes are ignored while RESET is low.
REQ-022 Decoded outputs are not reset; they follow Instr at all times.

Configuration
REQ-023 Macro ID_WRITE_BYPASS_EN selects write-through reads.
REQ-024 Defined: a read port whose index equals WriteReg while Write=1 and WriteReg!=0 SHALL return WriteData in the same cycle. Undefined: it returns the stored (old) value until the clock edge.

Structure
REQ-025 A shared package SHALL hold the opcode, funct and REGIMM-rt constants and the ALUControl encodings.
REQ-026 The register file SHALL be one sub-module, id_regfile; decode and next-address logic stay in the top module.

Verification
REQ-027 Reset, then write R5=0x12345678 and read rs=5 -> DataA=0x12345678; write R0=0xFFFFFFFF -> DataA for rs=0 is 0.
REQ-028 Instr=0x0C100004 (JAL), PC_Plus4=0x00400008 -> Jump=1, Link=1, DestReg=31, RegWrite=1, NextAddr=0x00400010.
REQ-029 Instr=0x1000FFFF (BEQ, imm -1), PC_Plus4=0x00400020 -> Branch=1, RegWrite=0, NextAddr=0x0040001C.
REQ-030 Instr=0x3484ABCD (ORI) -> SignOrZero=0, ALUSrc=1, RegWrite=1, DestReg=4, ALUControl=0x0D.
REQ-031 Instr=0x0000000C -> Syscall=1, RegWrite=0; Instr=0xFC000000 -> all flags 0.
REQ-032 Write=1, WriteReg=7, WriteData=0xA5A5A5A5 and rs=7 in the same cycle -> DataA=0xA5A5A5A5 before the edge only when ID_WRITE_BYPASS_EN is defined; the old value otherwise.

Source files
------------

// File: rtl/id_decode_unit_pkg.sv
// id_decode_unit_pkg: MIPS-I opcode, funct and REGIMM-rt constants, ALUControl encoding and decoded flag bundle.
package id_decode_unit_pkg;
  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
    OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
    OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
    OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
    OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25,
    OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B
  } opcode_e;
  typedef enum logic [5:0] {
    F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06,
    F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09, F_SYSCALL = 6'h0C,
    F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
    F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B
  } funct_e;
  typedef enum logic [4:0] {
    RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11
  } regimm_e;
  localparam logic [5:0] ALU_NOP = 6'h00;
  localparam logic [4:0] REG_RA = 5'd31;
  typedef struct packed {
    logic valid;
    logic link;
    logic reg_dest;
    logic jump;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic jump_register;
    logic sign_or_zero;
    logic syscall;
  } ctrl_t;
  function automatic logic [5:0] alu_code(logic [5:0] op, logic [5:0] funct, logic [4:0] rt);
    return op == OP_SPECIAL ? funct : op == OP_REGIMM ? {1'b1, rt} : op;
  endfunction
endpackage

// File: rtl/id_regfile.sv
// id_regfile: 32x32 register file, three combinational read ports, one write port, r0 hardwired to zero.
// ID_WRITE_BYPASS_EN makes a read of the register being written return WriteData in the same cycle.
module id_regfile (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic [4:0]  rc,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] qa,
  output logic [31:0] qb,
  output logic [31:0] qc
);
  logic [31:0] regs [32];
  logic [4:0]  a [3];
  logic [31:0] q [3];
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != '0) regs[wa] <= wd;
  assign a = '{ra, rb, rc};
  for (genvar g = 0; g < 3; g++) begin : g_rd
`ifdef ID_WRITE_BYPASS_EN
    assign q[g] = a[g] == '0 ? '0 : (RESET && we && a[g] == wa) ? wd : regs[a[g]];
`else
    assign q[g] = a[g] == '0 ? '0 : regs[a[g]];
`endif
  end
  assign qa = q[0];
  assign qb = q[1];
  assign qc = q[2];
endmodule

// File: rtl/id_decode_unit.sv
// id_decode_unit: MIPS-I instruction decode, branch/jump target and register-file reads.
// Write-through register reads are selected by ID_WRITE_BYPASS_EN.
module id_decode_unit
  import id_decode_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] PC_Plus4,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic        Write,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  output logic [31:0] DataC,
  output logic [4:0]  DestReg,
  output logic        Link,
  output logic        RegDest,
  output logic        Jump,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        JumpRegister,
  output logic        SignOrZero,
  output logic        Syscall,
  output logic [5:0]  ALUControl,
  output logic [31:0] NextAddr
);
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  ctrl_t c;
  assign op = Instr[31:26];
  assign rs = Instr[25:21];
  assign rt = Instr[20:16];
  assign rd = Instr[15:11];
  assign funct = Instr[5:0];
  always_comb begin
    c = '0;
    case (op)
      OP_SPECIAL: begin
        c.valid = funct inside {F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JR, F_JALR, F_SYSCALL,
                                F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
        c.reg_dest = c.valid && funct != F_JR && funct != F_SYSCALL;
        c.reg_write = c.reg_dest;
        c.jump = funct inside {F_JR, F_JALR};
        c.jump_register = c.jump;
        c.link = funct == F_JALR;
        c.syscall = funct == F_SYSCALL;
      end
      OP_REGIMM: begin
        c.valid = rt inside {RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL};
        c.branch = c.valid;
        c.link = rt inside {RT_BLTZAL, RT_BGEZAL};
        c.reg_write = c.link;
      end
      OP_J, OP_JAL: begin
        c.valid = 1'b1;
        c.jump = 1'b1;
        c.link = op == OP_JAL;
        c.reg_write = c.link;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        c.valid = 1'b1;
        c.branch = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.valid = 1'b1;
        c.alu_src = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        c.valid = 1'b1;
        c.alu_src = 1'b1;
        c.reg_write = 1'b1;
        c.mem_read = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        c.valid = 1'b1;
        c.alu_src = 1'b1;
        c.mem_write = 1'b1;
      end
      default: c = '0;
    endcase
    c.sign_or_zero = c.valid && !(op inside {OP_ANDI, OP_ORI, OP_XORI});
  end
  assign {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall} =
    {c.link, c.reg_dest, c.jump, c.branch, c.mem_read, c.mem_write, c.alu_src, c.reg_write,
     c.jump_register, c.sign_or_zero, c.syscall};
  assign ALUControl = c.valid ? alu_code(op, funct, rt) : ALU_NOP;
  assign DestReg = c.reg_dest ? rd : c.link ? REG_RA : rt;
  // Unsupported encodings still produce the branch-style target; it is harmless since no flag is set.
  assign NextAddr = c.jump_register ? DataA
                  : (op == OP_J || op == OP_JAL) ? {PC_Plus4[31:28], Instr[25:0], 2'b00}
                  : PC_Plus4 + {{14{Instr[15]}}, Instr[15:0], 2'b00};
  id_regfile u_rf (
    .CLK(CLK),
    .RESET(RESET),
    .ra(rs),
    .rb(rt),
    .rc(DestReg),
    .we(Write),
    .wa(WriteReg),
    .wd(WriteData),
    .qa(DataA),
    .qb(DataB),
    .qc(DataC)
  );
endmodule

// File: tb/tb_id_decode_unit.sv
// tb_id_decode_unit: directed vectors with a scoreboard queue drained by a negedge monitor.
module tb_id_decode_unit;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr, PC_Plus4, WriteData;
  logic [4:0]  WriteReg;
  logic        Write;
  logic [31:0] DataA, DataB, DataC, NextAddr;
  logic [4:0]  DestReg;
  logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall;
  logic [5:0]  ALUControl;

  id_decode_unit dut (
    .CLK(CLK), .RESET(RESET), .Instr(Instr), .PC_Plus4(PC_Plus4),
    .WriteReg(WriteReg), .WriteData(WriteData), .Write(Write),
    .DataA(DataA), .DataB(DataB), .DataC(DataC), .DestReg(DestReg),
    .Link(Link), .RegDest(RegDest), .Jump(Jump), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .JumpRegister(JumpRegister), .SignOrZero(SignOrZero), .Syscall(Syscall),
    .ALUControl(ALUControl), .NextAddr(NextAddr)
  );

  always #5 CLK = ~CLK;

  typedef enum {K_A, K_B, K_C, K_DEST, K_FLAGS, K_ALU, K_NEXT} kind_e;
  typedef struct {
    string       tag;
    kind_e       k;
    logic [31:0] v;
  } entry_t;

  entry_t sb[$];
  entry_t e;
  int n_vec = 0;
  int n_bad = 0;

  // flags packed as {Link,RegDest,Jump,Branch,MemRead,MemWrite,ALUSrc,RegWrite,JumpRegister,SignOrZero,Syscall}
  function automatic logic [31:0] observe(kind_e k);
    case (k)
      K_A:     return DataA;
      K_B:     return DataB;
      K_C:     return DataC;
      K_DEST:  return {27'd0, DestReg};
      K_FLAGS: return {21'd0, Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite,
                       JumpRegister, SignOrZero, Syscall};
      K_ALU:   return {26'd0, ALUControl};
      default: return NextAddr;
    endcase
  endfunction

  always @(negedge CLK)
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (observe(e.k) !== e.v) begin
        n_bad++;
        $display("FAIL %s %s: got %h, expected %h", e.tag, e.k.name(), observe(e.k), e.v);
      end
    end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp(input string tag, input kind_e k, input logic [31:0] v);
    sb.push_back('{tag, k, v});
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    Write = 1'b1;
    WriteReg = r;
    WriteData = d;
    step();
    Write = 1'b0;
  endtask

  task automatic dec(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [10:0] flags, input logic [5:0] alu, input logic [4:0] dst,
                     input logic [31:0] nxt);
    Instr = ins;
    PC_Plus4 = pc;
    exp(tag, K_FLAGS, {21'd0, flags});
    exp(tag, K_ALU, {26'd0, alu});
    exp(tag, K_DEST, {27'd0, dst});
    exp(tag, K_NEXT, nxt);
    step();
  endtask

  initial begin
    RESET = 1'b0;
    Write = 1'b1;
    WriteReg = 5'd5;
    WriteData = 32'hDEADBEEF;
    Instr = 32'h00A00020;
    PC_Plus4 = 32'h0;
    step();
    Write = 1'b0;
    exp("reset_r5", K_A, 32'h0);
    step();
    RESET = 1'b1;
    step();
    wr(5'd5, 32'h12345678);
    Instr = 32'h00A00020;
    exp("read_r5", K_A, 32'h12345678);
    step();
    wr(5'd0, 32'hFFFFFFFF);
    Instr = 32'h00000020;
    exp("read_r0", K_A, 32'h0);
    step();
    dec("add", 32'h00A00020, 32'h00400004, 11'h20A, 6'h20, 5'd0, 32'h00400084);
    dec("jal", 32'h0C100004, 32'h00400008, 11'h50A, 6'h03, 5'd31, 32'h00400010);
    dec("beq_m1", 32'h1000FFFF, 32'h00400020, 11'h082, 6'h04, 5'd0, 32'h0040001C);
    dec("ori", 32'h3484ABCD, 32'h00400000, 11'h018, 6'h0D, 5'd4, 32'h003EAF34);
    dec("syscall", 32'h0000000C, 32'h00400000, 11'h003, 6'h0C, 5'd0, 32'h00400030);
    dec("bad_op", 32'hFC000000, 32'h00400000, 11'h000, 6'h00, 5'd0, 32'h00400000);
    dec("bad_funct", 32'h00000001, 32'h00400000, 11'h000, 6'h00, 5'd0, 32'h00400004);
    dec("jr", 32'h00A00008, 32'h00400000, 11'h106, 6'h08, 5'd0, 32'h12345678);
    dec("jalr", 32'h00A0F809, 32'h00400000, 11'h70E, 6'h09, 5'd31, 32'h12345678);
    dec("bgezal", 32'h04B10004, 32'h00400000, 11'h48A, 6'h31, 5'd31, 32'h00400010);
    dec("lw", 32'h8CA60008, 32'h00400000, 11'h05A, 6'h23, 5'd6, 32'h00400020);
    dec("sw", 32'hACA60008, 32'h00400000, 11'h032, 6'h2B, 5'd6, 32'h00400020);
    dec("bne_wrap", 32'h14008000, 32'h00000004, 11'h082, 6'h05, 5'd0, 32'hFFFE0004);
    wr(5'd6, 32'hCAFEF00D);
    Instr = 32'h00062820;
    exp("ports", K_B, 32'hCAFEF00D);
    exp("ports", K_C, 32'h12345678);
    exp("ports", K_A, 32'h0);
    step();
    Write = 1'b1;
    WriteReg = 5'd7;
    WriteData = 32'hA5A5A5A5;
    Instr = 32'h00E00020;
`ifdef ID_WRITE_BYPASS_EN
    exp("same_cycle_r7", K_A, 32'hA5A5A5A5);
`else
    exp("same_cycle_r7", K_A, 32'h0);
`endif
    step();
    Write = 1'b0;
    exp("after_edge_r7", K_A, 32'hA5A5A5A5);
    step();
    RESET = 1'b0;
    exp("async_clear_r7", K_A, 32'h0);
    step();
    RESET = 1'b1;
    Instr = 32'h00A00020;
    exp("cleared_r5", K_A, 32'h0);
    step();
    step();
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
